// File: rtl/sync_uart_tx.sv
// Serial frame transmitter: 0x7E preamble, opt, len, payload, CRC-32; one bit per baud_en.
// Optional trailing idle gap enabled by defining SYNC_UART_TX_IDLE_GAP_EN.
//
// state   | meaning
// ST_IDLE | line high, waiting for a request
// ST_INIT | 7-bit 0x7E preamble, MSB first, raw bits
// ST_OPT  | option byte (start, 8 data LSB first, stop)
// ST_LEN  | length byte
// ST_DATA | payload bytes, byte_cnt runs len..1
// ST_CSM  | CRC-32 bytes, byte_cnt runs 4..1 (MSB byte first)
// ST_GAP  | GAP_BITS idle periods (only with SYNC_UART_TX_IDLE_GAP_EN)
module sync_uart_tx #(
  parameter int BYTE_SIZE    = 8,
  parameter int MAX_MSG_LEN  = (1 << BYTE_SIZE) - 1,
  parameter int IN_DATA_SIZE = $clog2(MAX_MSG_LEN) * BYTE_SIZE,
  parameter int GAP_BITS     = 2
) (
  input  logic                    CLK,
  input  logic                    RST_N,
  input  logic                    baud_en,
  input  logic                    i_valid,
  input  logic [BYTE_SIZE-1:0]    i_opt,
  input  logic [BYTE_SIZE-1:0]    i_len,
  input  logic [IN_DATA_SIZE-1:0] i_data,
  output logic                    o_ready,
  output logic                    o_bit,
  output logic                    o_busy,
  output logic                    o_done,
  output logic                    o_err
);

  localparam int DATA_BYTES = IN_DATA_SIZE / BYTE_SIZE;
  localparam int CRC_BYTES  = 32 / BYTE_SIZE;
  localparam int CNT_MAX    = (GAP_BITS > BYTE_SIZE + 1) ? GAP_BITS : BYTE_SIZE + 2;
  localparam int CNT_W      = $clog2(CNT_MAX);

  localparam logic [BYTE_SIZE-1:0] DATA_BYTES_L = BYTE_SIZE'(DATA_BYTES);
  localparam logic [BYTE_SIZE-1:0] CRC_BYTES_L  = BYTE_SIZE'(CRC_BYTES);
  localparam logic [BYTE_SIZE-1:0] LAST_BYTE    = BYTE_SIZE'(1);
  localparam logic [CNT_W-1:0]     BIT_LOAD     = CNT_W'(BYTE_SIZE + 1);
  localparam logic [CNT_W-1:0]     PRE_LOAD     = CNT_W'(6);
  localparam logic [31:0]          CRC_POLY     = 32'h04C11DB7;

`ifdef SYNC_UART_TX_IDLE_GAP_EN
  localparam logic [CNT_W-1:0] GAP_LOAD = CNT_W'(GAP_BITS - 1);
  typedef enum logic [2:0] {ST_IDLE, ST_INIT, ST_OPT, ST_LEN, ST_DATA, ST_CSM, ST_GAP} state_t;
`else
  typedef enum logic [2:0] {ST_IDLE, ST_INIT, ST_OPT, ST_LEN, ST_DATA, ST_CSM} state_t;
`endif

  state_t                  state;
  logic [CNT_W-1:0]        bit_cnt;
  logic [BYTE_SIZE-1:0]    byte_cnt;
  logic [6:0]              pre_sr;
  logic [BYTE_SIZE-1:0]    tx_sr;
  logic [BYTE_SIZE-1:0]    opt_q;
  logic [BYTE_SIZE-1:0]    len_q;
  logic [IN_DATA_SIZE-1:0] data_q;
  logic [31:0]             crc_q;
  logic [31:0]             crc_next;
  logic [BYTE_SIZE-1:0]    cur_byte;

  // Payload byte with counter value n lives at i_data[BYTE_SIZE*n-1 -: BYTE_SIZE]
  always_comb begin
    cur_byte = '0;
    case (state)
      ST_OPT:  cur_byte = opt_q;
      ST_LEN:  cur_byte = len_q;
      ST_DATA: begin
        for (int k = 0; k < DATA_BYTES; k++)
          if (byte_cnt == BYTE_SIZE'(k + 1)) cur_byte = data_q[BYTE_SIZE*k +: BYTE_SIZE];
      end
      ST_CSM: begin
        for (int k = 0; k < CRC_BYTES; k++)
          if (byte_cnt == BYTE_SIZE'(k + 1)) cur_byte = crc_q[BYTE_SIZE*k +: BYTE_SIZE];
      end
      default: cur_byte = '0;
    endcase
  end

  always_comb begin
    crc_next = {crc_q[30:0], 1'b0} ^ ((crc_q[31] ^ tx_sr[0]) ? CRC_POLY : 32'h0);
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state    <= ST_IDLE;
      bit_cnt  <= '0;
      byte_cnt <= '0;
      pre_sr   <= '0;
      tx_sr    <= '0;
      opt_q    <= '0;
      len_q    <= '0;
      data_q   <= '0;
      crc_q    <= '0;
      o_ready  <= 1'b1;
      o_bit    <= 1'b1;
      o_busy   <= 1'b0;
      o_done   <= 1'b0;
      o_err    <= 1'b0;
    end else begin
      o_done <= 1'b0;
      o_err  <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (i_valid && o_ready) begin
            if (i_len == '0 || i_len > DATA_BYTES_L) begin
              o_err <= 1'b1;
            end else begin
              state   <= ST_INIT;
              opt_q   <= i_opt;
              len_q   <= i_len;
              data_q  <= i_data;
              crc_q   <= '1;
              pre_sr  <= 7'h7E;
              bit_cnt <= PRE_LOAD;
              o_ready <= 1'b0;
              o_busy  <= 1'b1;
            end
          end
        end
        ST_INIT: begin
          if (baud_en) begin
            o_bit  <= pre_sr[6];
            pre_sr <= {pre_sr[5:0], 1'b0};
            if (bit_cnt == '0) begin
              state   <= ST_OPT;
              bit_cnt <= BIT_LOAD;
            end else begin
              bit_cnt <= bit_cnt - 1'b1;
            end
          end
        end
        ST_OPT, ST_LEN, ST_DATA, ST_CSM: begin
          if (baud_en) begin
            if (bit_cnt == BIT_LOAD) begin
              o_bit   <= 1'b0;
              tx_sr   <= cur_byte;
              bit_cnt <= bit_cnt - 1'b1;
            end else if (bit_cnt != '0) begin
              o_bit   <= tx_sr[0];
              tx_sr   <= tx_sr >> 1;
              bit_cnt <= bit_cnt - 1'b1;
              // CRC covers opt/len/payload data bits only and is frozen while it is sent
              if (state != ST_CSM) crc_q <= crc_next;
            end else begin
              o_bit   <= 1'b1;
              bit_cnt <= BIT_LOAD;
              case (state)
                ST_OPT: state <= ST_LEN;
                ST_LEN: begin
                  state    <= ST_DATA;
                  byte_cnt <= len_q;
                end
                ST_DATA: begin
                  if (byte_cnt == LAST_BYTE) begin
                    state    <= ST_CSM;
                    byte_cnt <= CRC_BYTES_L;
                  end else begin
                    byte_cnt <= byte_cnt - 1'b1;
                  end
                end
                default: begin
                  if (byte_cnt == LAST_BYTE) begin
`ifdef SYNC_UART_TX_IDLE_GAP_EN
                    state   <= ST_GAP;
                    bit_cnt <= GAP_LOAD;
`else
                    state   <= ST_IDLE;
                    o_done  <= 1'b1;
                    o_ready <= 1'b1;
                    o_busy  <= 1'b0;
`endif
                  end else begin
                    byte_cnt <= byte_cnt - 1'b1;
                  end
                end
              endcase
            end
          end
        end
`ifdef SYNC_UART_TX_IDLE_GAP_EN
        ST_GAP: begin
          if (baud_en) begin
            o_bit <= 1'b1;
            if (bit_cnt == '0) begin
              state   <= ST_IDLE;
              o_done  <= 1'b1;
              o_ready <= 1'b1;
              o_busy  <= 1'b0;
            end else begin
              bit_cnt <= bit_cnt - 1'b1;
            end
          end
        end
`endif
        default: begin
          state   <= ST_IDLE;
          o_bit   <= 1'b1;
          o_ready <= 1'b1;
          o_busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
